// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory widths, arbiter state encoding and requester indices.
package cpu_pkg;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 19;

    localparam logic REQ_LS = 1'b0;
    localparam logic REQ_IF = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between the load/store and fetch requesters.
module arb_pick
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       rr_en,
    output logic       winner,
    output logic       valid
);

    // Tie goes to r0 in fixed mode, or to whoever was not served last in round-robin mode
    always_comb begin
        winner = REQ_LS;
        valid  = |req;
        case (req)
            2'b01: winner = REQ_LS;
            2'b10: winner = REQ_IF;
            2'b11: begin
                if (rr_en) begin
                    winner = ~last_gnt;
                end else begin
                    winner = REQ_LS;
                end
            end
            default: winner = REQ_LS;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single data-memory port with fixed read latency.
// Define ARB_RR_EN for round-robin tie breaking; otherwise r0 has fixed priority.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t        state_r;
    arb_state_t        state_nx_s;
    logic [3:0]        lat_cnt_r;
    logic [3:0]        lat_cnt_nx_s;
    logic              last_gnt_r;
    logic              win_r;
    logic              pick_winner_s;
    logic              pick_valid_s;
    logic              grant_s;
    logic              capture_s;
    logic              done_set_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    arb_pick u_pick (
        .req      ({r1_req, r0_req}),
        .last_gnt (last_gnt_r),
        .rr_en    (RR_EN),
        .winner   (pick_winner_s),
        .valid    (pick_valid_s)
    );

    // Route the arbitration winner's request fields toward the memory registers
    always_comb begin
        if (pick_winner_s == REQ_IF) begin
            sel_we_s    = r1_we;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
        end else begin
            sel_we_s    = r0_we;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
        end
    end

    // Next-state logic; reads always spend MEM_LAT cycles in WAIT so the sample lands MEM_LAT cycles after ISSUE
    always_comb begin
        state_nx_s   = state_r;
        lat_cnt_nx_s = lat_cnt_r;
        grant_s      = 1'b0;
        capture_s    = 1'b0;
        done_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    grant_s    = 1'b1;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_write) begin
                    done_set_s = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    lat_cnt_nx_s = LAT_LOAD;
                    state_nx_s   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_r == 4'd0) begin
                    capture_s  = 1'b1;
                    done_set_s = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    lat_cnt_nx_s = lat_cnt_r - 4'd1;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State and latency counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            lat_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_nx_s;
            lat_cnt_r <= lat_cnt_nx_s;
        end
    end

    // Memory-side strobes, grant pulses and arbitration history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_en       <= 1'b0;
            mem_write    <= 1'b0;
            mem_address  <= {ADDR_W{1'b0}};
            mem_data_out <= {DATA_W{1'b0}};
            r0_gnt       <= 1'b0;
            r1_gnt       <= 1'b0;
            win_r        <= REQ_LS;
            last_gnt_r   <= 1'b1;
        end else begin
            mem_en    <= grant_s;
            mem_write <= grant_s & sel_we_s;
            r0_gnt    <= grant_s & (pick_winner_s == REQ_LS);
            r1_gnt    <= grant_s & (pick_winner_s == REQ_IF);
            if (grant_s) begin
                mem_address  <= sel_addr_s;
                mem_data_out <= sel_wdata_s;
                win_r        <= pick_winner_s;
                last_gnt_r   <= pick_winner_s;
            end
        end
    end

    // Completion pulses and per-requester read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_rdata <= {DATA_W{1'b0}};
            r1_rdata <= {DATA_W{1'b0}};
        end else begin
            r0_done <= done_set_s & (win_r == REQ_LS);
            r1_done <= done_set_s & (win_r == REQ_IF);
            if (capture_s) begin
                if (win_r == REQ_IF) begin
                    r1_rdata <= mem_data_in;
                end else begin
                    r0_rdata <= mem_data_in;
                end
            end
        end
    end

endmodule
